// File: rtl/kb_line_serializer.sv
// Replays a packed 32-bit word as up to four characters, first character first,
// followed by a terminator byte, over a valid/ready byte handshake.
module kb_line_serializer #(
  parameter logic [7:0] TERMINATOR = 8'h0D,
  parameter bit         SKIP_NULL  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] word_in,
  input  logic        word_valid,
  output logic        word_ready,
  output logic [7:0]  char_out,
  output logic        char_valid,
  input  logic        char_ready,
  output logic        busy
);

  // state | meaning
  // IDLE  | waiting for a word; word_ready high, nothing offered
  // SEND  | offering a character byte from the holding register
  // TERM  | offering the terminator byte
  typedef enum logic [1:0] {IDLE, SEND, TERM} state_t;

  state_t      state, state_nxt;
  logic [31:0] hold_q, hold_nxt;
  logic [3:0]  mask_q, mask_nxt;
  logic [7:0]  char_nxt;
  logic        valid_nxt;

  logic [3:0]  cap_mask, src_mask, rem_mask;
  logic [31:0] src_word;
  logic [1:0]  sel_idx;
  logic        sel_found;
  logic [7:0]  sel_byte;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      cap_mask[i] = SKIP_NULL ? (word_in[8*i +: 8] != 8'h00) : 1'b1;
    end
  end

  // In IDLE the encoder looks at the incoming word so the first byte is ready at capture.
  assign src_mask = (state == IDLE) ? cap_mask : mask_q;
  assign src_word = (state == IDLE) ? word_in  : hold_q;

  always_comb begin
    sel_idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (src_mask[i]) sel_idx = i[1:0];
    end
  end

  assign sel_found = |src_mask;
  assign rem_mask  = src_mask & ~(4'b0001 << sel_idx);
  assign sel_byte  = src_word[{sel_idx, 3'b000} +: 8];

  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_q;
    mask_nxt  = mask_q;
    char_nxt  = char_out;
    valid_nxt = char_valid;
    case (state)
      IDLE: begin
        if (word_valid) begin
          hold_nxt  = word_in;
          valid_nxt = 1'b1;
          if (sel_found) begin
            char_nxt  = sel_byte;
            mask_nxt  = rem_mask;
            state_nxt = SEND;
          end else begin
            char_nxt  = TERMINATOR;
            mask_nxt  = 4'b0000;
            state_nxt = TERM;
          end
        end
      end
      SEND: begin
        if (char_ready) begin
          if (sel_found) begin
            char_nxt = sel_byte;
            mask_nxt = rem_mask;
          end else begin
            char_nxt  = TERMINATOR;
            mask_nxt  = 4'b0000;
            state_nxt = TERM;
          end
        end
      end
      TERM: begin
        if (char_ready) begin
          valid_nxt = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: begin
        valid_nxt = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      hold_q     <= 32'h0;
      mask_q     <= 4'b0000;
      char_out   <= 8'h00;
      char_valid <= 1'b0;
    end else begin
      state      <= state_nxt;
      hold_q     <= hold_nxt;
      mask_q     <= mask_nxt;
      char_out   <= char_nxt;
      char_valid <= valid_nxt;
    end
  end

  assign word_ready = (state == IDLE);
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_kb_line_serializer.sv
// Bench for kb_line_serializer: two instances (null skipping on and off) checked
// every cycle against a queue model of the expected byte stream.
module tb_kb_line_serializer;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] word_in = 32'h0;
  logic        word_valid = 1'b0;
  logic        char_ready = 1'b0;

  logic       wr1, cv1, b1, wr0, cv0, b0;
  logic [7:0] co1, co0;

  bq_t q1, q0, log1, log0, exp_q;
  int  checks = 0;
  int  errors = 0;
  int  busy_cycles = 0;
  bit  pat[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  kb_line_serializer #(.TERMINATOR(8'h0D), .SKIP_NULL(1'b1)) dut1 (
    .clk(clk), .rst(rst), .word_in(word_in), .word_valid(word_valid), .word_ready(wr1),
    .char_out(co1), .char_valid(cv1), .char_ready(char_ready), .busy(b1));

  kb_line_serializer #(.TERMINATOR(8'h0D), .SKIP_NULL(1'b0)) dut0 (
    .clk(clk), .rst(rst), .word_in(word_in), .word_valid(word_valid), .word_ready(wr0),
    .char_out(co0), .char_valid(cv0), .char_ready(char_ready), .busy(b0));

  always #5 clk = ~clk;

  function automatic bq_t expand(input logic [31:0] w, input bit skip);
    bq_t r;
    logic [7:0] b;
    r = {};
    for (int i = 3; i >= 0; i--) begin
      b = w[8*i +: 8];
      if (!skip || b != 8'h00) r.push_back(b);
    end
    r.push_back(8'h0D);
    return r;
  endfunction

  // Model: a word is accepted only when its stream is fully drained; one byte leaves per ready cycle.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q1.delete();
      q0.delete();
    end else begin
      if (q1.size() != 0) begin
        if (char_ready) log1.push_back(q1.pop_front());
      end else if (word_valid) begin
        q1 = expand(word_in, 1'b1);
      end
      if (q0.size() != 0) begin
        if (char_ready) log0.push_back(q0.pop_front());
      end else if (word_valid) begin
        q0 = expand(word_in, 1'b0);
      end
    end
  end

  task automatic chk1(input string nm, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %b expected %b at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic chk8(input string nm, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic chk_int(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic chk_log(input string nm, input bq_t got, input bq_t exp);
    bit bad;
    int idx;
    bad = (got.size() != exp.size());
    idx = -1;
    for (int i = 0; i < got.size() && i < exp.size(); i++) begin
      if (!bad && got[i] !== exp[i]) begin
        bad = 1'b1;
        idx = i;
      end
    end
    checks++;
    if (bad) begin
      errors++;
      if (idx < 0) $display("FAIL %s stream length got %0d expected %0d", nm, got.size(), exp.size());
      else $display("FAIL %s byte %0d got %h expected %h", nm, idx, got[idx], exp[idx]);
    end
  endtask

  task automatic check_dut(input string nm, input logic v, input logic r, input logic b,
                           input logic [7:0] c, input bq_t q);
    if (!rst) begin
      chk1({nm, " rst char_valid"}, v, 1'b0);
      chk1({nm, " rst word_ready"}, r, 1'b1);
      chk1({nm, " rst busy"}, b, 1'b0);
      chk8({nm, " rst char_out"}, c, 8'h00);
    end else begin
      chk1({nm, " char_valid"}, v, q.size() != 0);
      chk1({nm, " word_ready"}, r, q.size() == 0);
      chk1({nm, " busy"}, b, q.size() != 0);
      if (q.size() != 0) chk8({nm, " char_out"}, c, q[0]);
    end
  endtask

  always @(negedge clk) begin
    check_dut("skip1", cv1, wr1, b1, co1, q1);
    check_dut("skip0", cv0, wr0, b0, co0, q0);
    if (rst && b1) busy_cycles++;
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic drain(input bit use_pat, input int start);
    int k;
    k = start;
    for (int n = 0; n < 80 && (q1.size() != 0 || q0.size() != 0); n++) begin
      char_ready = use_pat ? pat[k % 6] : 1'b1;
      k++;
      step();
    end
    chk1("drain completes", (q1.size() == 0) && (q0.size() == 0), 1'b1);
  endtask

  task automatic run_word(input logic [31:0] w, input bit use_pat);
    log1 = {};
    log0 = {};
    busy_cycles = 0;
    word_in = w;
    word_valid = 1'b1;
    char_ready = 1'b1;
    step();
    word_valid = 1'b0;
    drain(use_pat, 0);
  endtask

  initial begin
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();

    run_word(32'h41424344, 1'b0);
    exp_q = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h0D};
    chk_log("basic skip1", log1, exp_q);
    chk_int("basic busy cycles", busy_cycles, 5);

    run_word(32'h41004300, 1'b0);
    exp_q = '{8'h41, 8'h43, 8'h0D};
    chk_log("nulls skip1", log1, exp_q);
    chk_int("nulls busy cycles", busy_cycles, 3);
    exp_q = '{8'h41, 8'h00, 8'h43, 8'h00, 8'h0D};
    chk_log("nulls skip0", log0, exp_q);

    run_word(32'h00000000, 1'b0);
    exp_q = '{8'h0D};
    chk_log("empty skip1", log1, exp_q);
    chk_int("empty busy cycles", busy_cycles, 1);

    run_word(32'h31323334, 1'b1);
    exp_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h0D};
    chk_log("backpressure skip1", log1, exp_q);

    // Second word held valid throughout the first word's transmission.
    log1 = {};
    log0 = {};
    word_in = 32'h41424344;
    word_valid = 1'b1;
    char_ready = 1'b1;
    step();
    word_in = 32'h5A5A5A5A;
    for (int n = 0; n < 40 && log1.size() < 6; n++) step();
    word_valid = 1'b0;
    drain(1'b0, 0);
    exp_q = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h0D, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h0D};
    chk_log("busy rejection skip1", log1, exp_q);

    // Asynchronous reset while 8'h43 is on offer.
    log1 = {};
    word_in = 32'h41424344;
    word_valid = 1'b1;
    char_ready = 1'b1;
    step();
    word_valid = 1'b0;
    step();
    step();
    chk8("pre-reset char_out", co1, 8'h43);
    rst = 1'b0;
    #1;
    chk1("async rst char_valid", cv1, 1'b0);
    chk1("async rst word_ready", wr1, 1'b1);
    chk1("async rst busy", b1, 1'b0);
    chk1("async rst char_valid skip0", cv0, 1'b0);
    step();
    step();
    rst = 1'b1;
    for (int n = 0; n < 10; n++) step();
    exp_q = '{8'h41, 8'h42};
    chk_log("reset discards tail", log1, exp_q);

    // Randomised traffic with occasional asynchronous resets.
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] w;
      for (int i = 0; i < 4; i++) begin
        case ($urandom % 4)
          0: w[8*i +: 8] = 8'h00;
          1: w[8*i +: 8] = 8'h0D;
          default: w[8*i +: 8] = 8'($urandom);
        endcase
      end
      word_in = w;
      word_valid = ($urandom % 3) != 0;
      char_ready = ($urandom % 4) != 0;
      rst = ($urandom % 250) != 0;
      step();
    end
    rst = 1'b1;
    word_valid = 1'b0;
    drain(1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
